seg_scan_display: RTL and testbench

- Parametrised N-digit time-multiplexed seven-segment scan driver; successor to the fixed 4-digit display driver.
- Adds: configurable digit count, double-buffered display data (load strobe, no tearing), per-digit flash, leading-zero suppression, selectable output polarity.
- Sits between the datapath (ALU/number sources) and the board's anode/segment pins.
- Contains its own prescaler, so it needs no external divided clock.

---
 rtl/seg_scan_display.sv | 151 +++++++++++++++
 tb/tb_seg_scan_display.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/seg_scan_display.sv
// N-digit time-multiplexed seven-segment scan driver with double-buffered data,
// per-digit blank/flash, leading-zero suppression and selectable output polarity.
module seg_scan_display #(
    parameter int unsigned DIGITS     = 8,
    parameter int unsigned SCAN_DIV   = 17,
    parameter int unsigned FLASH_DIV  = 25,
    parameter int unsigned ACTIVE_LOW = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [4*DIGITS-1:0]        hexs,
    input  logic [DIGITS-1:0]          points,
    input  logic [DIGITS-1:0]          les,
    input  logic [DIGITS-1:0]          flash,
    input  logic                       lzs,
    input  logic                       load,
    output logic [DIGITS-1:0]          AN,
    output logic [7:0]                 SEGMENT,
    output logic [$clog2(DIGITS)-1:0]  digit_idx
);

    localparam int unsigned       IdxW    = $clog2(DIGITS);
    localparam logic [IdxW-1:0]   IdxLast = IdxW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AnOff   = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [7:0]        SegOff  = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    logic [FLASH_DIV-1:0] presc_q, presc_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [4*DIGITS-1:0]  hex_q, hex_d;
    logic [DIGITS-1:0]    points_q, points_d;
    logic [DIGITS-1:0]    les_q, les_d;
    logic [DIGITS-1:0]    flash_q, flash_d;
    logic [DIGITS-1:0]    an_q, an_d;
    logic [7:0]           seg_q, seg_d;
    logic [IdxW-1:0]      didx_q, didx_d;

    logic                 tick;
    logic                 phase;
    logic [3:0]           nib [DIGITS];
    logic [DIGITS-1:0]    lead_zero;
    logic                 zero_run;
    logic                 blank;
    logic [DIGITS-1:0]    an_act;
    logic [7:0]           seg_act;

    // Active-high gfedcba pattern for one hex nibble.
    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    always_comb begin
        presc_d = presc_q + 1'b1;
        tick    = &presc_q[SCAN_DIV-1:0];
        phase   = presc_q[FLASH_DIV-1];

        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
        end

        hex_d    = hex_q;
        points_d = points_q;
        les_d    = les_q;
        flash_d  = flash_q;
        if (load) begin
            hex_d    = hexs;
            points_d = points;
            les_d    = les;
            flash_d  = flash;
        end
    end

    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            nib[i] = hex_q[4*i +: 4];
        end
    end

    // Walk down from the most significant digit; a digit is a leading zero while
    // every nibble from the top down to it is zero. Digit 0 always shows.
    always_comb begin
        zero_run  = 1'b1;
        lead_zero = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run     = zero_run & (nib[i] == 4'h0);
            lead_zero[i] = zero_run;
        end
        lead_zero[0] = 1'b0;
    end

    always_comb begin
        an_act  = '0;
        seg_act = '0;
        blank   = les_q[idx_q] | (flash_q[idx_q] & ~phase);
        if (!blank) begin
            an_act[idx_q] = 1'b1;
            seg_act = {points_q[idx_q], (lzs && lead_zero[idx_q]) ? 7'h00 : decode(nib[idx_q])};
        end
        an_d   = (ACTIVE_LOW != 0) ? ~an_act : an_act;
        seg_d  = (ACTIVE_LOW != 0) ? ~seg_act : seg_act;
        didx_d = idx_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q  <= '0;
            idx_q    <= '0;
            hex_q    <= '0;
            points_q <= '0;
            les_q    <= '0;
            flash_q  <= '0;
            an_q     <= AnOff;
            seg_q    <= SegOff;
            didx_q   <= '0;
        end else begin
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            hex_q    <= hex_d;
            points_q <= points_d;
            les_q    <= les_d;
            flash_q  <= flash_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            didx_q   <= didx_d;
        end
    end

    assign AN        = an_q;
    assign SEGMENT   = seg_q;
    assign digit_idx = didx_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display (4 digits, fast prescaler): expected outputs are
// queued against future cycle numbers and checked by an independent monitor.
module tb_seg_scan_display;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] hexs;
    logic [3:0]  points, les, flash;
    logic        lzs, load;
    logic [3:0]  an;
    logic [7:0]  segment;
    logic [1:0]  digit_idx;

    seg_scan_display #(
        .DIGITS    (4),
        .SCAN_DIV  (2),
        .FLASH_DIV (4),
        .ACTIVE_LOW(1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .hexs     (hexs),
        .points   (points),
        .les      (les),
        .flash    (flash),
        .lzs      (lzs),
        .load     (load),
        .AN       (an),
        .SEGMENT  (segment),
        .digit_idx(digit_idx)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic [3:0]  an;
        logic [7:0]  seg;
        logic [1:0]  idx;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    int unsigned base  = 0;

    // k counts clock edges since the last reset edge (base).
    task automatic expect_at(input int unsigned k, input logic [3:0] an_e,
                             input logic [7:0] seg_e, input logic [1:0] idx_e,
                             input string name);
        exp_t x;
        x.cyc  = base + k;
        x.an   = an_e;
        x.seg  = seg_e;
        x.idx  = idx_e;
        x.name = name;
        sb.push_back(x);
    endtask

    task automatic to_k(input int unsigned k);
        while (cyc < base + k) @(negedge clk);
    endtask

    task automatic pulse_load();
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_vec++;
            if (e.cyc != cyc || an !== e.an || segment !== e.seg || digit_idx !== e.idx) begin
                n_bad++;
                $display("FAIL %s @cyc %0d: got AN=%b SEGMENT=%h idx=%0d, want AN=%b SEGMENT=%h idx=%0d (due cyc %0d)",
                         e.name, cyc, an, segment, digit_idx, e.an, e.seg, e.idx, e.cyc);
            end
        end
    end

    initial begin
        int unsigned w;
        hexs = '0; points = '0; les = '0; flash = '0; lzs = 1'b0; load = 1'b0;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        base = cyc;
        expect_at(1, 4'hF, 8'hFF, 2'd0, "reset_state");
        @(negedge clk);
        rst  = 1'b0;
        base = cyc;

        // 1: plain scan of 1234
        expect_at(1,  4'hE, 8'hC0, 2'd0, "t1_before_load");
        expect_at(2,  4'hE, 8'h99, 2'd0, "t1_d0_first");
        expect_at(4,  4'hE, 8'h99, 2'd0, "t1_d0_last");
        expect_at(5,  4'hD, 8'hB0, 2'd1, "t1_d1");
        expect_at(9,  4'hB, 8'hA4, 2'd2, "t1_d2");
        expect_at(13, 4'h7, 8'hF9, 2'd3, "t1_d3");
        expect_at(16, 4'h7, 8'hF9, 2'd3, "t1_d3_last");
        expect_at(17, 4'hE, 8'h99, 2'd0, "t1_wrap");
        hexs = 16'h1234;
        pulse_load();

        // 2: inputs ignored without load; load coincident with a tick
        to_k(17);
        hexs = 16'hFFFF;
        expect_at(21, 4'hD, 8'hB0, 2'd1, "t2_no_load");
        expect_at(24, 4'hD, 8'hB0, 2'd1, "t2_pre_tick");
        expect_at(25, 4'hB, 8'h8E, 2'd2, "t2_load_on_tick");
        to_k(23);
        pulse_load();

        // 3: leading-zero suppression with dp on a suppressed digit
        to_k(27);
        hexs = 16'h0070; lzs = 1'b1; points = 4'b1000;
        expect_at(29, 4'h7, 8'h7F, 2'd3, "t3_d3_dp_only");
        expect_at(33, 4'hE, 8'hC0, 2'd0, "t3_d0_zero");
        expect_at(37, 4'hD, 8'hF8, 2'd1, "t3_d1_seven");
        expect_at(41, 4'hB, 8'hFF, 2'd2, "t3_d2_suppressed");
        pulse_load();

        // 4: all-zero value keeps digit 0
        to_k(44);
        hexs = 16'h0000; points = 4'b0000;
        expect_at(46, 4'h7, 8'hFF, 2'd3, "t4_d3_blank");
        expect_at(49, 4'hE, 8'hC0, 2'd0, "t4_d0_zero");
        expect_at(53, 4'hD, 8'hFF, 2'd1, "t4_d1_blank");
        expect_at(57, 4'hB, 8'hFF, 2'd2, "t4_d2_blank");
        pulse_load();

        // 5: blanking and flash; digit 3 has both, blank wins
        to_k(60);
        hexs = 16'h0500; les = 4'b1010; flash = 4'b1101;
        expect_at(61, 4'h7, 8'hFF, 2'd3, "t5_before_load");
        expect_at(62, 4'hF, 8'hFF, 2'd3, "t5_les_over_flash");
        expect_at(65, 4'hF, 8'hFF, 2'd0, "t5_flash_off_phase");
        expect_at(69, 4'hF, 8'hFF, 2'd1, "t5_les_blank");
        expect_at(73, 4'hB, 8'h92, 2'd2, "t5_flash_on_phase");
        expect_at(74, 4'hB, 8'h92, 2'd2, "t5_flash_on_hold");
        pulse_load();

        // 6: reset mid-scan while idx is 2
        to_k(74);
        rst = 1'b1;
        expect_at(75, 4'hF, 8'hFF, 2'd0, "t6_reset_mid_scan");
        to_k(75);
        rst  = 1'b0;
        lzs  = 1'b0;
        base = cyc;
        expect_at(1, 4'hE, 8'hC0, 2'd0, "t6_restart_d0");
        expect_at(5, 4'hD, 8'hC0, 2'd1, "t6_shadow_cleared_d1");
        to_k(8);

        w = 0;
        while (sb.size() > 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations never checked, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
